qubit_readout_collector: RTL and testbench

- Parametrised output stage of the camera preprocessing chain. It follows the bank of N parallel Gaussian filter engines.
- Collects per-lane qubit decisions, tagged with a base ID, into a complete per-frame qubit state vector. It checks coverage, duplicates and timeout.
- Streams the frame vector as OUT_W-bit words with valid/ready back-pressure, plus a frame population count.
- Replaces the fixed 4-lane, unbuffered state stream with a generalised, frame-framed and flow-controlled interface.

---
 rtl/qubit_readout_collector.sv | 268 ++++++++++++++++++++++++++
 tb/tb_qubit_readout_collector.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qubit_readout_collector.sv
// qubit_readout_collector: assembles lane decisions into a per-frame qubit
// state vector and streams it out as flow-controlled words with a popcount.
module qubit_readout_collector #(
  parameter int NUM_LANES   = 4,
  parameter int NUM_QUBITS  = 100,
  parameter int ID_W        = 7,
  parameter int OUT_W       = 32,
  parameter int TIMEOUT_CYC = 1024,
  localparam int NUM_WORDS  = (NUM_QUBITS + OUT_W - 1) / OUT_W,
  localparam int CNT_W      = $clog2(NUM_QUBITS + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_frame_start,
  input  logic                 i_valid,
  input  logic [ID_W-1:0]      i_base_id,
  input  logic [NUM_LANES-1:0] i_decision,
  output logic [OUT_W-1:0]     o_word,
  output logic                 o_word_valid,
  input  logic                 i_word_ready,
  output logic                 o_word_last,
  output logic [CNT_W-1:0]     o_ones_count,
  output logic                 o_err_timeout,
  output logic                 o_err_dup,
  output logic                 o_err_overrun,
  output logic                 o_err_orphan,
  output logic                 o_busy
);
  localparam int IW = ID_W + 4;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int WI = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int PW = NUM_WORDS * OUT_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_EMIT
  } state_e;

  state_e state_q, state_d;

  logic [NUM_QUBITS-1:0] vec_q, vec_d;
  logic [NUM_QUBITS-1:0] seen_q, seen_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dup_q, dup_d;
  logic                  tout_q, tout_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  pend_q, pend_d;
  logic                  ent_q, ent_d;
  logic                  ld_q, ld_d;
  logic [WI-1:0]         widx_q, widx_d;
  logic [OUT_W-1:0]      word_q, word_d;
  logic                  wval_q, wval_d;
  logic                  wlast_q, wlast_d;
  logic [CNT_W-1:0]      ones_q, ones_d;
  logic                  etout_q, etout_d;
  logic                  edup_q, edup_d;
  logic                  ovr_q, ovr_d;
  logic                  orph_q, orph_d;

  logic                  coll, beat, tmo, comp, close, xfer_last;
  logic [IW-1:0]         lidx;
  logic [NUM_QUBITS-1:0] hit, hbit, vb, sb;
  logic [CNT_W-1:0]      cb, add, cnt_new, pc;
  logic                  db;
  logic [PW-1:0]         vpad;
  logic [WI-1:0]         nidx;
  logic [OUT_W-1:0]      nword;
  logic                  nlast;

  // A start seen in IDLE makes this cycle act as the first COLLECT cycle.
  assign coll = (state_q == S_COLLECT) ||
                (state_q == S_IDLE && i_frame_start);
  assign beat = coll && i_valid;
  assign tmo  = (state_q == S_COLLECT) && !i_frame_start && !i_valid &&
                (timer_q == TW'(TIMEOUT_CYC - 1));
  assign close = comp || tmo;
  assign xfer_last = (state_q == S_EMIT) && wval_q && wlast_q &&
                     i_word_ready;

  always_comb begin
    lidx = '0;
    hit  = '0;
    hbit = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lidx = IW'(i_base_id) + IW'(k);
      for (int q = 0; q < NUM_QUBITS; q++) begin
        if (lidx == IW'(q)) begin
          hit[q]  = beat;
          hbit[q] = i_decision[k];
        end
      end
    end
  end

  // Merge the beat onto the frame (freshly cleared if a start coincides).
  always_comb begin
    vb  = i_frame_start ? '0 : vec_q;
    sb  = i_frame_start ? '0 : seen_q;
    cb  = i_frame_start ? '0 : cnt_q;
    db  = i_frame_start ? 1'b0 : dup_q;
    add = '0;
    for (int q = 0; q < NUM_QUBITS; q++) begin
      if (hit[q]) begin
        if (sb[q]) db = 1'b1;
        else       add = add + CNT_W'(1);
        vb[q] = hbit[q];
        sb[q] = 1'b1;
      end
    end
    cnt_new = cb + add;
    comp    = beat && (cnt_new == CNT_W'(NUM_QUBITS));
  end

  always_comb begin
    vpad = '0;
    vpad[NUM_QUBITS-1:0] = vec_q;
    nidx  = ld_q ? '0 : widx_q + WI'(1);
    nword = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (nidx == WI'(w)) nword = vpad[w*OUT_W +: OUT_W];
    end
    nlast = (nidx == WI'(NUM_WORDS - 1));
    pc = '0;
    for (int q = 0; q < NUM_QUBITS; q++) begin
      pc = pc + CNT_W'(vec_q[q]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_frame_start) state_d = close ? S_EMIT : S_COLLECT;
      end
      S_COLLECT: begin
        if (close) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (xfer_last)
          state_d = (pend_q || i_frame_start) ? S_COLLECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vec_d   = vec_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    dup_d   = dup_q;
    tout_d  = tout_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    ent_d   = 1'b0;
    ld_d    = 1'b0;
    widx_d  = widx_q;
    word_d  = word_q;
    wval_d  = wval_q;
    wlast_d = wlast_q;
    ones_d  = ones_q;
    etout_d = etout_q;
    edup_d  = edup_q;
    ovr_d   = ((state_q == S_EMIT) && (i_valid || i_frame_start)) ||
              ((state_q == S_COLLECT) && i_frame_start);
    orph_d  = (state_q == S_IDLE) && i_valid && !i_frame_start;
    if (coll) begin
      vec_d   = vb;
      seen_d  = sb;
      cnt_d   = cnt_new;
      dup_d   = db;
      timer_d = (i_frame_start || i_valid) ? '0 : timer_q + TW'(1);
      tout_d  = tmo && !comp;
      ent_d   = close;
    end
    if (state_q == S_EMIT) begin
      if (ent_q) begin
        ones_d = pc;
        ld_d   = 1'b1;
      end
      if (ld_q || (wval_q && i_word_ready && !wlast_q)) begin
        widx_d  = nidx;
        word_d  = nword;
        wval_d  = 1'b1;
        wlast_d = nlast;
        etout_d = nlast && tout_q;
        edup_d  = nlast && dup_q;
      end
      if (i_frame_start) pend_d = 1'b1;
      if (xfer_last) begin
        vec_d   = '0;
        seen_d  = '0;
        cnt_d   = '0;
        dup_d   = 1'b0;
        tout_d  = 1'b0;
        timer_d = '0;
        pend_d  = 1'b0;
        widx_d  = '0;
        word_d  = '0;
        wval_d  = 1'b0;
        wlast_d = 1'b0;
        ones_d  = '0;
        etout_d = 1'b0;
        edup_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vec_q   <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
      dup_q   <= 1'b0;
      tout_q  <= 1'b0;
      timer_q <= '0;
      pend_q  <= 1'b0;
      ent_q   <= 1'b0;
      ld_q    <= 1'b0;
      widx_q  <= '0;
      word_q  <= '0;
      wval_q  <= 1'b0;
      wlast_q <= 1'b0;
      ones_q  <= '0;
      etout_q <= 1'b0;
      edup_q  <= 1'b0;
      ovr_q   <= 1'b0;
      orph_q  <= 1'b0;
    end else begin
      vec_q   <= vec_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      dup_q   <= dup_d;
      tout_q  <= tout_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ent_q   <= ent_d;
      ld_q    <= ld_d;
      widx_q  <= widx_d;
      word_q  <= word_d;
      wval_q  <= wval_d;
      wlast_q <= wlast_d;
      ones_q  <= ones_d;
      etout_q <= etout_d;
      edup_q  <= edup_d;
      ovr_q   <= ovr_d;
      orph_q  <= orph_d;
    end
  end

  always_comb begin
    o_word        = word_q;
    o_word_valid  = wval_q;
    o_word_last   = wlast_q;
    o_ones_count  = ones_q;
    o_err_timeout = etout_q;
    o_err_dup     = edup_q;
    o_err_overrun = ovr_q;
    o_err_orphan  = orph_q;
    o_busy        = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_qubit_readout_collector.sv
// tb_qubit_readout_collector: randomized frames checked against an
// array-based model of the frame vector, plus directed corner cases.
module tb_qubit_readout_collector;
  localparam int NQ = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, valid, ready;
  logic [6:0]  base;
  logic [3:0]  dec;
  logic [31:0] word;
  logic        wv, last, tout, dup, ovr, orph, busy;
  logic [6:0]  ones;

  logic        start2, valid2, ready2;
  logic [6:0]  base2;
  logic [7:0]  dec2;
  logic [63:0] word2;
  logic        wv2, last2, tout2, dup2, ovr2, orph2, busy2;
  logic [6:0]  ones2;

  qubit_readout_collector dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(start),
    .i_valid(valid), .i_base_id(base), .i_decision(dec),
    .o_word(word), .o_word_valid(wv), .i_word_ready(ready),
    .o_word_last(last), .o_ones_count(ones), .o_err_timeout(tout),
    .o_err_dup(dup), .o_err_overrun(ovr), .o_err_orphan(orph),
    .o_busy(busy)
  );

  qubit_readout_collector #(
    .NUM_LANES(8), .NUM_QUBITS(64), .OUT_W(64)
  ) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(start2),
    .i_valid(valid2), .i_base_id(base2), .i_decision(dec2),
    .o_word(word2), .o_word_valid(wv2), .i_word_ready(ready2),
    .o_word_last(last2), .o_ones_count(ones2), .o_err_timeout(tout2),
    .o_err_dup(dup2), .o_err_overrun(ovr2), .o_err_orphan(orph2),
    .o_busy(busy2)
  );

  int vec_n = 0;
  int err_n = 0;

  // Reference frame: value and seen flag per qubit.
  bit mv [NQ];
  bit ms [NQ];
  int mcnt;
  bit mdup;

  logic [31:0] got_word [8];
  int          got_n, first_v, hold_bad;
  bit          got_done;
  logic [6:0]  got_ones;
  logic        got_tout, got_dup;

  task automatic m_start();
    for (int i = 0; i < NQ; i++) begin
      mv[i] = 1'b0;
      ms[i] = 1'b0;
    end
    mcnt = 0;
    mdup = 1'b0;
  endtask

  task automatic m_beat(input int b, input logic [3:0] d);
    for (int k = 0; k < 4; k++) begin
      if (b + k < NQ) begin
        if (ms[b+k]) mdup = 1'b1;
        else         mcnt++;
        ms[b+k] = 1'b1;
        mv[b+k] = d[k];
      end
    end
  endtask

  function automatic logic [31:0] m_word(input int w);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 32; j++)
      if (w * 32 + j < NQ) r[j] = mv[w*32+j];
    return r;
  endfunction

  function automatic int m_ones();
    int n;
    n = 0;
    for (int i = 0; i < NQ; i++) n += int'(mv[i]);
    return n;
  endfunction

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
    valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    valid = 1'b0;
    m_start();
  endtask

  task automatic beat(input int b, input logic [3:0] d);
    @(negedge clk);
    start = 1'b0;
    valid = 1'b1;
    base  = 7'(b);
    dec   = d;
    m_beat(b, d);
  endtask

  task automatic start_beat(input int b, input logic [3:0] d);
    @(negedge clk);
    start = 1'b1;
    valid = 1'b1;
    base  = 7'(b);
    dec   = d;
    m_start();
    m_beat(b, d);
  endtask

  task automatic fill_frame(input bit rnd);
    pulse_start();
    for (int b = 0; b < NQ; b += 4)
      beat(b, rnd ? 4'($urandom) : 4'b0101);
  endtask

  // Sink: mode 0 ready=1, mode 1 ready pattern 1,0,0,1, mode 2 random.
  task automatic recv(input int mode, input int budget);
    logic [31:0] prev;
    bit stall;
    int pi;
    got_n = 0; hold_bad = 0; first_v = -1; got_done = 1'b0;
    stall = 1'b0; pi = 0; prev = '0;
    for (int i = 0; i < 8; i++) got_word[i] = 'x;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (mode == 0)      ready = 1'b1;
      else if (mode == 1) ready = (pi % 4 == 0) || (pi % 4 == 3);
      else                ready = 1'($urandom_range(0, 1));
      if (stall && (wv !== 1'b1 || word !== prev)) hold_bad++;
      stall = (wv === 1'b1) && !ready;
      prev  = word;
      if (wv === 1'b1) begin
        if (first_v < 0) first_v = c;
        pi++;
        if (ready) begin
          if (got_n < 8) got_word[got_n] = word;
          got_n++;
          if (last === 1'b1) begin
            got_ones = ones;
            got_tout = tout;
            got_dup  = dup;
            got_done = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            return;
          end
        end
      end
    end
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; base = '0; dec = '0;
    ready = 1'b0; start2 = 1'b0; valid2 = 1'b0; base2 = '0;
    dec2 = '0; ready2 = 1'b0;
    repeat (3) @(negedge clk);
    vec_n++; if (wv !== 1'b0 || word !== '0 || last !== 1'b0) begin
      err_n++; $display("FAIL rst_word v=%b w=%h l=%b exp 0", wv, word, last);
    end
    vec_n++; if (ones !== '0 || tout !== 1'b0 || dup !== 1'b0) begin
      err_n++; $display("FAIL rst_flags ones=%0d t=%b d=%b exp 0", ones, tout, dup);
    end
    vec_n++; if (ovr !== 1'b0 || orph !== 1'b0 || busy !== 1'b0) begin
      err_n++; $display("FAIL rst_status o=%b r=%b b=%b exp 0", ovr, orph, busy);
    end
    vec_n++; if (wv2 !== 1'b0 || busy2 !== 1'b0) begin
      err_n++; $display("FAIL rst_dut2 v=%b b=%b exp 0", wv2, busy2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full();
    fill_frame(1'b0);
    idle();
    vec_n++; if (wv !== 1'b0) begin
      err_n++; $display("FAIL full_lat1 valid=%b exp 0", wv);
    end
    idle();
    vec_n++; if (wv !== 1'b0) begin
      err_n++; $display("FAIL full_lat2 valid=%b exp 0", wv);
    end
    recv(0, 50);
    vec_n++; if (!got_done || got_n != 4 || first_v != 0) begin
      err_n++; $display("FAIL full_xfer done=%b n=%0d first=%0d exp 1 4 0", got_done, got_n, first_v);
    end
    for (int w = 0; w < 4; w++) begin
      vec_n++; if (got_word[w] !== m_word(w)) begin
        err_n++; $display("FAIL full_word%0d got %h exp %h", w, got_word[w], m_word(w));
      end
    end
    vec_n++; if (got_ones !== 7'd50 || got_tout !== 1'b0 || got_dup !== 1'b0) begin
      err_n++; $display("FAIL full_last ones=%0d t=%b d=%b exp 50 0 0", got_ones, got_tout, got_dup);
    end
    vec_n++; if (busy !== 1'b0) begin
      err_n++; $display("FAIL full_idle busy=%b exp 0", busy);
    end
  endtask

  task automatic test_timeout();
    pulse_start();
    for (int b = 0; b <= 92; b += 4) beat(b, 4'($urandom));
    idle();
    recv(0, 1200);
    vec_n++; if (!got_done || got_n != 4) begin
      err_n++; $display("FAIL tmo_xfer done=%b n=%0d exp 1 4", got_done, got_n);
    end
    for (int w = 0; w < 4; w++) begin
      vec_n++; if (got_word[w] !== m_word(w)) begin
        err_n++; $display("FAIL tmo_word%0d got %h exp %h", w, got_word[w], m_word(w));
      end
    end
    vec_n++; if (got_word[3] !== 32'h0) begin
      err_n++; $display("FAIL tmo_word3 got %h exp 0", got_word[3]);
    end
    vec_n++; if (got_tout !== 1'b1 || got_dup !== 1'b0 || got_ones !== 7'(m_ones())) begin
      err_n++; $display("FAIL tmo_last t=%b d=%b ones=%0d exp 1 0 %0d", got_tout, got_dup, got_ones, m_ones());
    end
  endtask

  task automatic test_dup();
    pulse_start();
    beat(0, 4'($urandom));
    beat(4, 4'($urandom));
    beat(8, 4'($urandom));
    beat(4, 4'($urandom));
    for (int b = 12; b < NQ; b += 4) beat(b, 4'($urandom));
    idle();
    recv(0, 50);
    vec_n++; if (!got_done || got_n != 4) begin
      err_n++; $display("FAIL dup_xfer done=%b n=%0d exp 1 4", got_done, got_n);
    end
    for (int w = 0; w < 4; w++) begin
      vec_n++; if (got_word[w] !== m_word(w)) begin
        err_n++; $display("FAIL dup_word%0d got %h exp %h", w, got_word[w], m_word(w));
      end
    end
    vec_n++; if (got_dup !== 1'b1 || got_tout !== 1'b0 || got_ones !== 7'(m_ones())) begin
      err_n++; $display("FAIL dup_last d=%b t=%b ones=%0d exp 1 0 %0d", got_dup, got_tout, got_ones, m_ones());
    end
  endtask

  task automatic test_backpressure();
    fill_frame(1'b1);
    idle();
    recv(1, 100);
    vec_n++; if (!got_done || got_n != 4 || hold_bad != 0) begin
      err_n++; $display("FAIL bp_xfer done=%b n=%0d hold_bad=%0d exp 1 4 0", got_done, got_n, hold_bad);
    end
    for (int w = 0; w < 4; w++) begin
      vec_n++; if (got_word[w] !== m_word(w)) begin
        err_n++; $display("FAIL bp_word%0d got %h exp %h", w, got_word[w], m_word(w));
      end
    end
    vec_n++; if (got_ones !== 7'(m_ones())) begin
      err_n++; $display("FAIL bp_ones got %0d exp %0d", got_ones, m_ones());
    end
  endtask

  task automatic test_orphan();
    @(negedge clk);
    valid = 1'b1;
    base  = 7'd12;
    dec   = 4'hF;
    idle();
    vec_n++; if (orph !== 1'b1 || busy !== 1'b0) begin
      err_n++; $display("FAIL orphan_pulse orph=%b busy=%b exp 1 0", orph, busy);
    end
    idle();
    vec_n++; if (orph !== 1'b0) begin
      err_n++; $display("FAIL orphan_clear orph=%b exp 0", orph);
    end
  endtask

  task automatic test_overrun();
    fill_frame(1'b1);
    idle();
    @(negedge clk);
    start = 1'b1;
    valid = 1'b1;
    base  = 7'd0;
    dec   = 4'hF;
    idle();
    vec_n++; if (ovr !== 1'b1 || busy !== 1'b1) begin
      err_n++; $display("FAIL ovr_emit ovr=%b busy=%b exp 1 1", ovr, busy);
    end
    recv(0, 50);
    vec_n++; if (!got_done || got_n != 4) begin
      err_n++; $display("FAIL ovr_xfer done=%b n=%0d exp 1 4", got_done, got_n);
    end
    for (int w = 0; w < 4; w++) begin
      vec_n++; if (got_word[w] !== m_word(w)) begin
        err_n++; $display("FAIL ovr_word%0d got %h exp %h", w, got_word[w], m_word(w));
      end
    end
    vec_n++; if (busy !== 1'b1 || wv !== 1'b0) begin
      err_n++; $display("FAIL ovr_pending busy=%b valid=%b exp 1 0", busy, wv);
    end
    m_start();
    beat(0, 4'hF);
    start_beat(8, 4'($urandom));
    idle();
    vec_n++; if (ovr !== 1'b1) begin
      err_n++; $display("FAIL ovr_collect ovr=%b exp 1", ovr);
    end
    for (int b = 0; b < NQ; b += 4)
      if (b != 8) beat(b, 4'($urandom));
    idle();
    recv(0, 50);
    vec_n++; if (!got_done || got_n != 4 || got_dup !== 1'b0) begin
      err_n++; $display("FAIL ovr_restart done=%b n=%0d dup=%b exp 1 4 0", got_done, got_n, got_dup);
    end
    for (int w = 0; w < 4; w++) begin
      vec_n++; if (got_word[w] !== m_word(w)) begin
        err_n++; $display("FAIL ovr_rword%0d got %h exp %h", w, got_word[w], m_word(w));
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    pulse_start();
    for (int b = 0; b < 20; b += 4) beat(b, 4'hF);
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vec_n++; if (busy !== 1'b0 || wv !== 1'b0 || word !== '0 || ones !== '0) begin
      err_n++; $display("FAIL rmid_out busy=%b v=%b w=%h ones=%0d exp 0", busy, wv, word, ones);
    end
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      ready = 1'b1;
      if (wv !== 1'b0 || busy !== 1'b0) seen++;
    end
    ready = 1'b0;
    vec_n++; if (seen != 0) begin
      err_n++; $display("FAIL rmid_quiet active_cycles=%0d exp 0", seen);
    end
  endtask

  task automatic test_random();
    int order [25];
    int t, j;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 25; i++) order[i] = i * 4;
      for (int i = 24; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      pulse_start();
      for (int i = 0; i < 25 && mcnt < NQ; i++) begin
        if ($urandom_range(0, 4) == 0)
          beat($urandom_range(0, NQ - 1), 4'($urandom));
        if (mcnt < NQ) beat(order[i], 4'($urandom));
        repeat ($urandom_range(0, 2)) idle();
      end
      idle();
      recv(2, 600);
      vec_n++; if (!got_done || got_n != 4 || hold_bad != 0) begin
        err_n++; $display("FAIL rnd%0d_xfer done=%b n=%0d hold_bad=%0d", f, got_done, got_n, hold_bad);
      end
      for (int w = 0; w < 4; w++) begin
        vec_n++; if (got_word[w] !== m_word(w)) begin
          err_n++; $display("FAIL rnd%0d_word%0d got %h exp %h", f, w, got_word[w], m_word(w));
        end
      end
      vec_n++; if (got_ones !== 7'(m_ones()) || got_dup !== mdup || got_tout !== 1'b0) begin
        err_n++; $display("FAIL rnd%0d_last ones=%0d d=%b t=%b exp %0d %b 0", f, got_ones, got_dup, got_tout, m_ones(), mdup);
      end
    end
  endtask

  task automatic test_wide();
    logic [63:0] exp;
    logic [7:0]  d;
    int c, n1;
    for (int f = 0; f < 3; f++) begin
      exp = '0;
      @(negedge clk);
      start2 = 1'b1;
      valid2 = 1'b0;
      for (int b = 0; b < 64; b += 8) begin
        d = (f == 0) ? 8'hFF : 8'($urandom);
        @(negedge clk);
        start2 = 1'b0;
        valid2 = 1'b1;
        base2  = 7'(b);
        dec2   = d;
        exp[b +: 8] = d;
      end
      @(negedge clk);
      valid2 = 1'b0;
      ready2 = 1'b1;
      c = 0;
      while (wv2 !== 1'b1 && c < 10) begin
        @(negedge clk);
        c++;
      end
      n1 = 0;
      for (int i = 0; i < 64; i++) n1 += int'(exp[i]);
      vec_n++; if (wv2 !== 1'b1 || last2 !== 1'b1 || word2 !== exp) begin
        err_n++; $display("FAIL wide%0d_word v=%b l=%b got %h exp %h", f, wv2, last2, word2, exp);
      end
      vec_n++; if (ones2 !== 7'(n1) || tout2 !== 1'b0 || dup2 !== 1'b0) begin
        err_n++; $display("FAIL wide%0d_flags ones=%0d t=%b d=%b exp %0d 0 0", f, ones2, tout2, dup2, n1);
      end
      @(negedge clk);
      ready2 = 1'b0;
      vec_n++; if (busy2 !== 1'b0 || wv2 !== 1'b0) begin
        err_n++; $display("FAIL wide%0d_done busy=%b v=%b exp 0 0", f, busy2, wv2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_timeout();
    test_dup();
    test_backpressure();
    test_orphan();
    test_overrun();
    test_reset_mid();
    test_random();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
